// File: rtl/bmp_pixel_streamer.sv
// Streams a 24-bpp BMP pixel array from byte-wide memory as packed raster pixels with hsync/vsync.
// Define BMP_TOP_DOWN_EN to fetch rows last-to-first so the output stream is top-down.
module bmp_pixel_streamer #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int ADDR_W     = 20,
  parameter int BASE       = 0,
  parameter int PIXEL_SIZE = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_data,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  valid,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  busy,
  output logic                  done
);

  localparam int PAD       = (4 - (3 * WIDTH) % 4) % 4;
  localparam int ROW_BYTES = 3 * WIDTH + PAD;
  localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
`ifdef BMP_TOP_DOWN_EN
  localparam logic [ADDR_W-1:0] FIRST_ROW = ADDR_W'(BASE + (HEIGHT - 1) * ROW_BYTES);
`else
  localparam logic [ADDR_W-1:0] FIRST_ROW = ADDR_W'(BASE);
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PAD_SKIP, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        phase, rd_phase;
  logic [COL_W-1:0]  col, ocol;
  logic [ROW_W-1:0]  row, orow;
  logic              rd_q, pend, emit;
  logic [15:0]       pack;
  logic [23:0]       pix_q;
`ifdef BMP_TOP_DOWN_EN
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_base;
  assign next_base = row_base - ADDR_W'(ROW_BYTES);
`endif

  // A finished pixel waits in pend until an enabled cycle lets it out.
  assign emit     = en & pend;
  assign mem_rd   = en & (state == S_FETCH);
  assign mem_addr = addr_q;
  assign data     = PIXEL_SIZE'(pix_q);
  assign valid    = emit;
  assign hsync    = emit & (ocol == '0);
  assign vsync    = emit & (ocol == '0) & (orow == '0);
  assign busy     = (state == S_FETCH) | (state == S_PAD_SKIP) | (state == S_DRAIN);
  assign done     = en & (state == S_DONE);

  // NOTE: every register here is updated with <= so all right-hand sides see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      phase    <= '0;
      rd_phase <= '0;
      col      <= '0;
      row      <= '0;
      ocol     <= '0;
      orow     <= '0;
      rd_q     <= 1'b0;
      pend     <= 1'b0;
      pack     <= '0;
      pix_q    <= '0;
`ifdef BMP_TOP_DOWN_EN
      row_base <= '0;
`endif
    end else begin
      rd_q     <= mem_rd;
      rd_phase <= phase;

      if (emit) begin
        pend <= 1'b0;
        if (ocol == LAST_COL) begin
          ocol <= '0;
          orow <= (orow == LAST_ROW) ? '0 : orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end

      // Returned bytes are captured regardless of en so a stall never loses data.
      if (rd_q) begin
        case (rd_phase)
          2'd0:    pack[7:0]  <= mem_data;
          2'd1:    pack[15:8] <= mem_data;
          default: begin
            pix_q <= {mem_data, pack};
            pend  <= 1'b1;
          end
        endcase
      end

      if (en) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state  <= S_FETCH;
              addr_q <= FIRST_ROW;
              phase  <= '0;
              col    <= '0;
              row    <= '0;
              ocol   <= '0;
              orow   <= '0;
`ifdef BMP_TOP_DOWN_EN
              row_base <= FIRST_ROW;
`endif
            end
          end
          S_FETCH: begin
            addr_q <= addr_q + 1'b1;
            if (phase != 2'd2) begin
              phase <= phase + 1'b1;
            end else begin
              phase <= '0;
              if (col != LAST_COL) begin
                col <= col + 1'b1;
              end else begin
                col <= '0;
                if (row == LAST_ROW) begin
                  row   <= '0;
                  state <= S_DRAIN;
                end else begin
                  row <= row + 1'b1;
`ifdef BMP_TOP_DOWN_EN
                  row_base <= next_base;
                  if (PAD == 0) addr_q <= next_base;
`endif
                  if (PAD != 0) state <= S_PAD_SKIP;
                end
              end
            end
          end
          S_PAD_SKIP: begin
`ifdef BMP_TOP_DOWN_EN
            addr_q <= row_base;
`else
            addr_q <= addr_q + ADDR_W'(PAD);
`endif
            state <= S_FETCH;
          end
          S_DRAIN: begin
            // Last pixel is out once it leaves pend with no capture still in flight.
            if (pend && !rd_q) state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
